// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals between the ARM datapath,
// the load/store sequencer and the word-addressed data memory.
interface load_store_unit_if;
    logic        Req;
    logic        Write;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Ready;
    logic        Done;
    logic        Fault;
    logic [31:0] RData;
    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic        MemWE;
    logic [31:0] MemRD;

    modport master (
        output Req, Write, Size, Signed, Addr, WData, MemRD,
        input  Ready, Done, Fault, RData, MemA, MemWD, MemWE
    );

    modport slave (
        input  Req, Write, Size, Signed, Addr, WData, MemRD,
        output Ready, Done, Fault, RData, MemA, MemWD, MemWE
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: byte/halfword/word access with sign or zero extension,
// sub-word stores by read-modify-write, misaligned/out-of-range rejection.
module load_store_unit #(
    parameter int unsigned Depth = 128
) (
    input logic              Clk,
    input logic              Rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, MERGE, WRITE} state_t;

    state_t      state, state_d;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [15:0] wdata_q;
    logic [31:0] mema_q;
    logic [31:0] memwd_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        fault_q;

    logic        accept;
    logic        bad_req;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign accept = bus.Req && (state == IDLE);

    always_comb begin
        bad_req = 1'b0;
        case (bus.Size)
            2'b01:   bad_req = bus.Addr[0];
            2'b10:   bad_req = (bus.Addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
        if ({2'b00, bus.Addr[31:2]} >= Depth)
            bad_req = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept && !bad_req) begin
                    if (!bus.Write)
                        state_d = LOAD;
                    else if (bus.Size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = MERGE;
                end
            end
            LOAD:    state_d = IDLE;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        rd_byte  = bus.MemRD[{lane_q, 3'b000} +: 8];
        rd_half  = bus.MemRD[{lane_q[1], 4'b0000} +: 16];
        load_val = bus.MemRD;
        case (size_q)
            2'b00:   load_val = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: load_val = bus.MemRD;
        endcase
    end

    always_comb begin
        merge_val = bus.MemRD;
        if (size_q == 2'b00)
            merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lane_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            mema_q  <= '0;
            memwd_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            if (accept) begin
                if (bad_req) begin
                    done_q  <= 1'b1;
                    fault_q <= 1'b1;
                end else begin
                    lane_q  <= bus.Addr[1:0];
                    size_q  <= bus.Size;
                    sgn_q   <= bus.Signed;
                    wdata_q <= bus.WData[15:0];
                    mema_q  <= {bus.Addr[31:2], 2'b00};
                    // Word stores skip MERGE, so their write data is loaded here.
                    if (bus.Write && bus.Size == 2'b10)
                        memwd_q <= bus.WData;
                end
            end
            case (state)
                LOAD: begin
                    rdata_q <= load_val;
                    done_q  <= 1'b1;
                end
                MERGE:   memwd_q <= merge_val;
                WRITE:   done_q  <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.Ready = (state == IDLE);
    assign bus.MemWE = (state == WRITE);
    assign bus.Done  = done_q;
    assign bus.Fault = fault_q;
    assign bus.RData = rdata_q;
    assign bus.MemA  = mema_q;
    assign bus.MemWD = memwd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a behavioural data memory and
// a scoreboard queue matching each Done pulse against the issued request.
module tb_load_store_unit;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.Depth(128)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] mem [128] = '{default: '0};
    assign bus.MemRD = mem[bus.MemA[8:2]];
    always @(posedge Clk) if (bus.MemWE) mem[bus.MemA[8:2]] <= bus.MemWD;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic        chk_rd;
        logic        fault;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned acc;
        int unsigned idx;
    } exp_t;

    localparam int unsigned NV = 24;
    vec_t tbl [NV];
    exp_t sb [$];

    int total = 0;
    int bad = 0;
    int unsigned we_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (bus.MemWE) we_cycles++;
        if (bus.Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("req%0d_fault", e.idx), 32'(bus.Fault), 32'(e.fault));
                chk($sformatf("req%0d_latency", e.idx), cyc - e.acc, e.lat);
                if (e.chk_rd)
                    chk($sformatf("req%0d_rdata", e.idx), bus.RData, e.rdata);
            end
        end
    end

    // Presents a request at a falling edge and keeps Req high until accepted.
    task automatic issue(input vec_t v, input int unsigned idx, output int unsigned acc);
        int unsigned waits;
        exp_t e;
        waits = 0;
        acc = 0;
        @(negedge Clk);
        bus.Req    = 1'b1;
        bus.Write  = v.write;
        bus.Size   = v.size;
        bus.Signed = v.sgn;
        bus.Addr   = v.addr;
        bus.WData  = v.wdata;
        while (!bus.Ready && waits < 40) begin
            @(negedge Clk);
            waits++;
        end
        if (!bus.Ready) begin
            chk($sformatf("req%0d_accept_timeout", idx), 32'd0, 32'd1);
            bus.Req = 1'b0;
        end else begin
            acc = cyc;
            e.chk_rd = !v.write && !v.fault;
            e.fault  = v.fault;
            e.rdata  = v.rdata;
            e.lat    = v.lat;
            e.acc    = cyc;
            e.idx    = idx;
            sb.push_back(e);
            @(posedge Clk);
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.Ready), 32'd1);
        chk({tag, "_done"},  32'(bus.Done),  32'd0);
        chk({tag, "_fault"}, 32'(bus.Fault), 32'd0);
        chk({tag, "_rdata"}, bus.RData, 32'h0);
        chk({tag, "_mema"},  bus.MemA,  32'h0);
        chk({tag, "_memwd"}, bus.MemWD, 32'h0);
        chk({tag, "_memwe"}, 32'(bus.MemWE), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned acc, prev_acc, prev_lat;
        vec_t v;

        //          wr    size   sgn   addr           wdata          flt   rdata          lat
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 1'b0, 32'h0,         2};
        tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0,         1'b0, 32'h0000_0033, 2};
        tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         1'b0, 32'h0000_1122, 2};
        tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_000A, 32'hFFFF_FFAB, 1'b0, 32'h0,         3};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_000A, 32'h0,         1'b0, 32'hFFFF_FFAB, 2};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h11AB_3344, 2};
        tbl[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0009, 32'h0000_DEAD, 1'b1, 32'h0,         1};
        tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 1'b1, 32'h0,         1};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h0,         1};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h5555_AAAA, 1'b1, 32'h0,         1};
        tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_0008, 32'h1234_BEEF, 1'b0, 32'h0,         3};
        tbl[11] = '{1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,         1'b0, 32'hFFFF_BEEF, 2};
        tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         1'b0, 32'h0000_11AB, 2};
        tbl[13] = '{1'b1, 2'b00, 1'b0, 32'h0000_01FF, 32'h0000_0080, 1'b0, 32'h0,         3};
        tbl[14] = '{1'b0, 2'b00, 1'b1, 32'h0000_01FF, 32'h0,         1'b0, 32'hFFFF_FF80, 2};
        tbl[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_01FF, 32'h0,         1'b0, 32'h0000_0080, 2};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'h8000_0000, 2};
        tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h0000_01FC, 32'hCAFE_F00D, 1'b0, 32'h0,         2};
        tbl[18] = '{1'b0, 2'b01, 1'b0, 32'h0000_01FE, 32'h0,         1'b0, 32'h0000_CAFE, 2};
        tbl[19] = '{1'b0, 2'b00, 1'b1, 32'h0000_01FD, 32'h0,         1'b0, 32'hFFFF_FFF0, 2};
        tbl[20] = '{1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         1};
        tbl[21] = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h11AB_BEEF, 2};
        tbl[22] = '{1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 32'h0000_0000, 2};
        tbl[23] = '{1'b0, 2'b10, 1'b1, 32'h0000_01FC, 32'h0,         1'b0, 32'hCAFE_F00D, 2};

        bus.Req    = 1'b0;
        bus.Write  = 1'b0;
        bus.Size   = 2'b00;
        bus.Signed = 1'b0;
        bus.Addr   = '0;
        bus.WData  = '0;

        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_reset_outputs("reset");

        // Req stays high throughout, so each accept must land on the prior Done.
        prev_acc = 0;
        prev_lat = 0;
        for (int i = 0; i < int'(NV); i++) begin
            issue(tbl[i], i, acc);
            if (i > 0)
                chk($sformatf("b2b_accept_gap_%0d", i), acc - prev_acc, prev_lat);
            prev_acc = acc;
            prev_lat = tbl[i].lat;
        end
        @(negedge Clk);
        bus.Req = 1'b0;
        drain();

        chk("mem2_after_table",   mem[2],   32'h11AB_BEEF);
        chk("mem127_after_table", mem[127], 32'hCAFE_F00D);
        chk("mem1_untouched",     mem[1],   32'h0);
        chk("mem0_untouched",     mem[0],   32'h0);
        chk("write_cycles_table", we_cycles, 32'd5);

        // Reset pulsed while a byte store sits in MERGE.
        @(negedge Clk);
        bus.Req    = 1'b1;
        bus.Write  = 1'b1;
        bus.Size   = 2'b00;
        bus.Signed = 1'b0;
        bus.Addr   = 32'h0000_0008;
        bus.WData  = 32'h0000_0055;
        chk("rst_seq_ready_before", 32'(bus.Ready), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        bus.Req = 1'b0;
        chk("rst_seq_in_merge_ready", 32'(bus.Ready), 32'd0);
        chk("rst_seq_in_merge_we",    32'(bus.MemWE), 32'd0);
        #2 Rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_reset_outputs("postrst");
        chk("mem2_after_reset",  mem[2], 32'h11AB_BEEF);
        chk("write_cycles_reset", we_cycles, 32'd5);

        v = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h11AB_BEEF, 2};
        issue(v, 100, acc);
        v = '{1'b1, 2'b00, 1'b0, 32'h0000_000B, 32'h0000_0077, 1'b0, 32'h0, 3};
        issue(v, 101, acc);
        v = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h77AB_BEEF, 2};
        issue(v, 102, acc);
        @(negedge Clk);
        bus.Req = 1'b0;
        drain();
        repeat (3) @(negedge Clk);
        chk("mem2_final",        mem[2], 32'h77AB_BEEF);
        chk("write_cycles_final", we_cycles, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
